// File: rtl/attribute_stream_buffer.sv
// attribute_stream_buffer: FWFT elastic buffer behind the attribute interpolator.
// The interpolator cannot be stalled, so this block hands out issue credits.
// One credit covers each slot that is either stored or still in the 28-cycle pipeline.
// An upstream stage that respects the credits can therefore never overflow the FIFO.
module attribute_stream_buffer #(
  parameter int DATA_WIDTH = 160,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issueValid,
  output logic                  issueReady,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [DEPTH_LOG2:0]   fillLevel,
  output logic                  pixelInPipeline,
  output logic                  overflow,
  output logic                  creditError
);

  localparam int          PW     = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH  = 2 ** DEPTH_LOG2;
  localparam logic [PW:0] DEPTH_W = (PW + 1)'(DEPTH);

  logic [DATA_WIDTH:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       count;
  logic [PW-1:0]       in_flight;
  logic [PW-1:0]       count_next;
  logic [PW-1:0]       in_flight_next;
  logic [PW:0]         committed;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                issue;
  logic                wr_en;

  assign full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Credits: stored entries plus pixels still inside the interpolator.
  assign committed  = {1'b0, count} + {1'b0, in_flight};
  assign issueReady = !reset && (committed < DEPTH_W);

  assign push  = s_axis_tvalid;
  assign pop   = !empty && m_axis_tready;
  assign issue = issueValid && issueReady;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);

  assign m_axis_tvalid                = !empty;
  assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[PW-2:0]];
  assign fillLevel                    = count;

  // Next occupancy and next outstanding-credit count.
  always_comb begin
    count_next     = count;
    in_flight_next = in_flight;
    case ({wr_en, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
    if (issue && !push) begin
      in_flight_next = in_flight + 1'b1;
    end else if (push && !issue && (in_flight != '0)) begin
      in_flight_next = in_flight - 1'b1;
    end
  end

  // Payload storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr[PW-2:0]] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // Pointers, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      in_flight       <= '0;
      pixelInPipeline <= 1'b0;
      overflow        <= 1'b0;
      creditError     <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count           <= count_next;
      in_flight       <= in_flight_next;
      pixelInPipeline <= (count_next != '0) || (in_flight_next != '0);
      if (push && full && !pop) begin
        overflow <= 1'b1;
      end
      if (push && !issue && (in_flight == '0)) begin
        creditError <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_attribute_stream_buffer.sv
// Bench for attribute_stream_buffer: queue-based reference model checked every
// cycle, an emulated 28-cycle interpolator, and directed scenarios with literal values.
module tb_attribute_stream_buffer;

  logic         clk = 1'b0;
  logic         reset;
  logic         issueValid;
  logic         issueReady;
  logic         s_axis_tvalid;
  logic         s_axis_tlast;
  logic [159:0] s_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic         m_axis_tlast;
  logic [159:0] m_axis_tdata;
  logic [6:0]   fillLevel;
  logic         pixelInPipeline;
  logic         overflow;
  logic         creditError;

  attribute_stream_buffer #(.DATA_WIDTH(160), .DEPTH_LOG2(6)) dut (
    .clk(clk), .reset(reset), .issueValid(issueValid), .issueReady(issueReady),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .fillLevel(fillLevel), .pixelInPipeline(pixelInPipeline),
    .overflow(overflow), .creditError(creditError)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [159:0] gen(input int unsigned s);
    return {s, ~s, s ^ 32'h5555_AAAA, s + 32'd1, s * 32'd7};
  endfunction

  // Reference model: an ordered queue of {tlast, data}, a credit count, sticky flags.
  logic [160:0] mq[$];
  int           m_inflight = 0;
  bit           m_ovf = 0;
  bit           m_cerr = 0;
  bit           model_ok = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_inflight = 0;
      m_ovf      = 0;
      m_cerr     = 0;
      model_ok   = 1;
    end else if (model_ok) begin
      bit m_full, m_pop, m_issue, m_push;
      m_full  = (mq.size() == 64);
      m_pop   = (mq.size() != 0) && m_axis_tready;
      m_issue = issueValid && (mq.size() + m_inflight < 64);
      m_push  = s_axis_tvalid;
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        if (!m_full || m_pop) mq.push_back({s_axis_tlast, s_axis_tdata});
        else m_ovf = 1;
      end
      if (m_issue && !m_push) m_inflight++;
      else if (m_push && !m_issue) begin
        if (m_inflight == 0) m_cerr = 1;
        else m_inflight--;
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (model_ok) begin
      int n;
      n = mq.size();
      chk("issueReady", 160'(issueReady), 160'(!reset && (n + m_inflight < 64)));
      chk("tvalid", 160'(m_axis_tvalid), 160'(n != 0));
      if (n != 0) begin
        chk("tdata", m_axis_tdata, mq[0][159:0]);
        chk("tlast", 160'(m_axis_tlast), 160'(mq[0][160]));
      end
      chk("fillLevel", 160'(fillLevel), 160'(n));
      chk("pixelInPipeline", 160'(pixelInPipeline), 160'((n != 0) || (m_inflight != 0)));
      chk("overflow", 160'(overflow), 160'(m_ovf));
      chk("creditError", 160'(creditError), 160'(m_cerr));
    end
  end

  // Interpolator emulation: every granted issue arrives 28 edges later.
  typedef struct {
    int           at_edge;
    logic         last;
    logic [159:0] data;
  } arr_t;

  arr_t         aq[$];
  int           cyc = 0;
  int unsigned  seq = 0;
  bit           ovr_en = 0;
  logic [159:0] ovr_data;
  bit           ovr_last;

  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
  endtask

  task automatic step(input bit iv, input bit tr, input bit fp,
                      input logic [159:0] fdata, input bit flast);
    bit ready_now;
    ready_now     = !reset && (mq.size() + m_inflight < 64);
    issueValid    = iv;
    m_axis_tready = tr;
    if (iv && ready_now) begin
      arr_t a;
      a.at_edge = cyc + 29;
      if (ovr_en) begin
        a.data = ovr_data;
        a.last = ovr_last;
        ovr_en = 0;
      end else begin
        a.data = gen(seq);
        a.last = (seq % 5 == 4);
        seq++;
      end
      aq.push_back(a);
    end
    if (aq.size() != 0 && aq[0].at_edge == cyc + 1) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = aq[0].data;
      s_axis_tlast  = aq[0].last;
      void'(aq.pop_front());
    end else if (fp) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = fdata;
      s_axis_tlast  = flast;
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
    end
    tick();
  endtask

  task automatic idle(input bit tr);
    step(1'b0, tr, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    issueValid    = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = '0;
    m_axis_tready = 1'b0;
    aq.delete();
    seq = 0;
    for (int i = 0; i < 3; i++) tick();
    chk("rst_issueReady", 160'(issueReady), 160'(0));
    chk("rst_tvalid", 160'(m_axis_tvalid), 160'(0));
    chk("rst_fillLevel", 160'(fillLevel), 160'(0));
    chk("rst_pip", 160'(pixelInPipeline), 160'(0));
    reset = 1'b0;
    #1;
    chk("rel_issueReady", 160'(issueReady), 160'(1));
  endtask

  initial begin
    int  wait_n;
    int  expect_idx;
    bit  seen;

    do_reset();

    // 64 credited issues with no downstream drain; arrivals fill the FIFO exactly.
    for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    chk("t1_fillLevel", 160'(fillLevel), 160'(64));
    chk("t1_issueReady", 160'(issueReady), 160'(0));
    chk("t1_overflow", 160'(overflow), 160'(0));

    // Uncredited push into a full FIFO: dropped, both sticky flags set, head kept.
    step(1'b0, 1'b0, 1'b1, {5{32'hDEAD_BEEF}}, 1'b1);
    chk("t4_overflow", 160'(overflow), 160'(1));
    chk("t4_fillLevel", 160'(fillLevel), 160'(64));
    chk("t4_head", m_axis_tdata, gen(0));
    chk("t4_creditError", 160'(creditError), 160'(1));

    // Single pixel through an empty FIFO: visible one cycle after it arrives.
    do_reset();
    ovr_en   = 1;
    ovr_data = {5{32'hA5A5_A5A5}};
    ovr_last = 1'b1;
    step(1'b1, 1'b0, 1'b0, '0, 1'b0);
    wait_n = 0;
    seen   = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      idle(1'b0);
      if (m_axis_tvalid) begin
        seen   = 1;
        wait_n = i;
      end
    end
    chk("t2_latency", 160'(wait_n), 160'(28));
    chk("t2_tdata", m_axis_tdata, {5{32'hA5A5_A5A5}});
    chk("t2_tlast", 160'(m_axis_tlast), 160'(1));
    idle(1'b1);
    chk("t2_tvalid_after_pop", 160'(m_axis_tvalid), 160'(0));

    // Push with no credit outstanding.
    do_reset();
    step(1'b0, 1'b0, 1'b1, gen(77), 1'b0);
    chk("t5_creditError", 160'(creditError), 160'(1));
    chk("t5_fillLevel", 160'(fillLevel), 160'(1));
    idle(1'b1);
    chk("t5_pip_drained", 160'(pixelInPipeline), 160'(0));
    chk("t5_issueReady", 160'(issueReady), 160'(1));

    // Full FIFO with simultaneous push and pop, sequence 0..99 across pointer wrap.
    do_reset();
    for (int i = 0; i < 64; i++) step(1'b0, 1'b0, 1'b1, gen(i), 1'b0);
    chk("t3_full", 160'(fillLevel), 160'(64));
    for (int i = 64; i < 100; i++) begin
      chk("t3_head_pp", 160'(m_axis_tdata[159:128]), 160'(i - 64));
      step(1'b0, 1'b1, 1'b1, gen(i), 1'b0);
      chk("t3_level_pp", 160'(fillLevel), 160'(64));
    end
    expect_idx = 36;
    for (int i = 0; i < 100 && m_axis_tvalid; i++) begin
      chk("t3_head_drain", 160'(m_axis_tdata[159:128]), 160'(expect_idx));
      expect_idx++;
      idle(1'b1);
    end
    chk("t3_count", 160'(expect_idx), 160'(100));
    chk("t3_overflow", 160'(overflow), 160'(0));

    // Random issue/backpressure with credited arrivals only.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      int thr;
      thr = (i < 5000) ? 25 : 75;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < thr, 1'b0, '0, 1'b0);
    end
    for (int i = 0; i < 200; i++) idle(1'b1);
    chk("t6_overflow", 160'(overflow), 160'(0));
    chk("t6_creditError", 160'(creditError), 160'(0));
    chk("t6_fillLevel", 160'(fillLevel), 160'(0));
    chk("t6_pip", 160'(pixelInPipeline), 160'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
